// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 streaming blocks.
// Contents:
//   - default widths for the S RAM data/address and the message index
//   - byte_t, the byte type shared by the data paths
//   - state_t, the PRGA sequencing state of the encryptor
package rc4_pkg;

    localparam int RAM_WIDTH_DEF          = 8;
    localparam int RAM_LENGTH_DEF         = 8;
    localparam int MESSAGE_LOG_LENGTH_DEF = 5;

    typedef logic [RAM_WIDTH_DEF-1:0] byte_t;

    // One PRGA step walks FETCH_I .. WAIT_IN, which is eight cycles per byte.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH_I   = 4'd1,
        ST_READ_SI   = 4'd2,
        ST_READ_SJ   = 4'd3,
        ST_WRITE_SI  = 4'd4,
        ST_WRITE_SJ  = 4'd5,
        ST_ISSUE_F   = 4'd6,
        ST_CAPTURE_F = 4'd7,
        ST_WAIT_IN   = 4'd8,
        ST_DONE      = 4'd9
    } state_t;

endpackage

// File: rtl/rc4_encryptor_if.sv
// Bus bundle for the RC4 encryptor.
// Groups the S RAM port (sOut/sIn/sAddr/sWren), the plaintext input
// stream (in_data/in_valid/in_ready) and the ciphertext output stream
// (out_data/out_idx/out_valid/out_ready).
//   master : the encryptor (drives the RAM port, sinks plaintext, sources ciphertext)
//   slave  : the environment (RAM, plaintext source, ciphertext sink)
interface rc4_encryptor_if #(
    parameter int RAM_WIDTH          = 8,
    parameter int RAM_LENGTH         = 8,
    parameter int MESSAGE_LOG_LENGTH = 5
);
    logic [RAM_WIDTH-1:0]          sOut;
    logic [RAM_WIDTH-1:0]          sIn;
    logic [RAM_LENGTH-1:0]         sAddr;
    logic                          sWren;
    logic [RAM_WIDTH-1:0]          in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [RAM_WIDTH-1:0]          out_data;
    logic [MESSAGE_LOG_LENGTH-1:0] out_idx;
    logic                          out_valid;
    logic                          out_ready;

    modport master (
        input  sOut,
        output sIn, sAddr, sWren,
        input  in_data, in_valid,
        output in_ready,
        output out_data, out_idx, out_valid,
        input  out_ready
    );

    modport slave (
        output sOut,
        input  sIn, sAddr, sWren,
        output in_data, in_valid,
        input  in_ready,
        input  out_data, out_idx, out_valid,
        output out_ready
    );
endinterface

// File: rtl/rc4_encryptor_edge_detector.sv
// Registered rising-edge detector.
// Ports:
//   clk   - clock
//   reset - synchronous active-low reset
//   level - level input to watch
//   pulse - one-cycle pulse, one cycle after a 0->1 transition of level is sampled
module edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);
    logic level_d_r;
    logic pulse_r;

    // Delay the level by one sample and register the rising-edge pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            level_d_r <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            level_d_r <= level;
            pulse_r   <= level & ~level_d_r;
        end
    end

    assign pulse = pulse_r;
endmodule

// File: rtl/rc4_encryptor.sv
// Streaming RC4 encryptor (PRGA against an already keyed S RAM).
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   start           - level; a rising edge launches a message
//   msg_len         - byte count, latched on the start edge
//   bus (master)    - S RAM port, plaintext stream in, ciphertext stream out
//   busy            - high whenever the block is not idle
//   finished        - one-cycle pulse after the last plaintext byte is taken
module rc4_encryptor
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH          = RAM_WIDTH_DEF,
    parameter int RAM_LENGTH         = RAM_LENGTH_DEF,
    parameter int MESSAGE_LOG_LENGTH = MESSAGE_LOG_LENGTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [MESSAGE_LOG_LENGTH:0] msg_len,
    rc4_encryptor_if.master             bus,
    output logic                        busy,
    output logic                        finished
);
    localparam logic [RAM_LENGTH-1:0]         IDX_ONE = {{(RAM_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [MESSAGE_LOG_LENGTH-1:0] K_ONE   = {{(MESSAGE_LOG_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [MESSAGE_LOG_LENGTH:0]   LEN_ONE = {{MESSAGE_LOG_LENGTH{1'b0}}, 1'b1};

    state_t                        state_r, state_s;
    logic [RAM_LENGTH-1:0]         i_r, j_r;
    logic [MESSAGE_LOG_LENGTH-1:0] k_r;
    logic [MESSAGE_LOG_LENGTH:0]   len_r;
    logic [RAM_WIDTH-1:0]          si_r, sj_r, ks_r;
    logic [RAM_WIDTH-1:0]          out_data_r;
    logic [MESSAGE_LOG_LENGTH-1:0] out_idx_r;
    logic                          out_valid_r;

    logic                          start_rise_s;
    logic [RAM_LENGTH-1:0]         sout_idx_s;
    logic [RAM_LENGTH-1:0]         addr_s;
    logic [RAM_WIDTH-1:0]          sin_s;
    logic                          wren_s;
    logic                          in_ready_s;
    logic                          accept_s;
    logic                          last_s;

    edge_detector u_start_edge (
        .clk   (clk),
        .reset (reset),
        .level (start),
        .pulse (start_rise_s)
    );

    // S values double as S addresses for the j update and the keystream read.
    assign sout_idx_s = RAM_LENGTH'(bus.sOut);
    assign last_s     = ({1'b0, k_r} == (len_r - LEN_ONE));

    // Next-state decode plus the S RAM port and input handshake for the current step.
    always_comb begin
        state_s    = state_r;
        addr_s     = '0;
        sin_s      = '0;
        wren_s     = 1'b0;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    state_s = (msg_len == '0) ? ST_DONE : ST_FETCH_I;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH_I: begin
                addr_s  = i_r + IDX_ONE;
                state_s = ST_READ_SI;
            end
            ST_READ_SI: begin
                addr_s  = j_r + sout_idx_s;
                state_s = ST_READ_SJ;
            end
            ST_READ_SJ: begin
                state_s = ST_WRITE_SI;
            end
            ST_WRITE_SI: begin
                addr_s  = i_r;
                sin_s   = sj_r;
                wren_s  = 1'b1;
                state_s = ST_WRITE_SJ;
            end
            ST_WRITE_SJ: begin
                // With i==j this rewrites the same cell with the same value.
                addr_s  = j_r;
                sin_s   = si_r;
                wren_s  = 1'b1;
                state_s = ST_ISSUE_F;
            end
            ST_ISSUE_F: begin
                addr_s  = RAM_LENGTH'(si_r + sj_r);
                state_s = ST_CAPTURE_F;
            end
            ST_CAPTURE_F: begin
                state_s = ST_WAIT_IN;
            end
            ST_WAIT_IN: begin
                // A pending output that is leaving this cycle frees the register.
                in_ready_s = !out_valid_r || bus.out_ready;
                accept_s   = bus.in_valid && in_ready_s;
                if (accept_s) begin
                    state_s = last_s ? ST_DONE : ST_FETCH_I;
                end else begin
                    state_s = ST_WAIT_IN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, PRGA datapath registers and the ciphertext output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            i_r         <= '0;
            j_r         <= '0;
            k_r         <= '0;
            len_r       <= '0;
            si_r        <= '0;
            sj_r        <= '0;
            ks_r        <= '0;
            out_data_r  <= '0;
            out_idx_r   <= '0;
            out_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_rise_s) begin
                        len_r <= msg_len;
                        i_r   <= '0;
                        j_r   <= '0;
                        k_r   <= '0;
                    end
                end
                ST_FETCH_I: begin
                    i_r <= i_r + IDX_ONE;
                end
                ST_READ_SI: begin
                    si_r <= bus.sOut;
                    j_r  <= j_r + sout_idx_s;
                end
                ST_READ_SJ: begin
                    sj_r <= bus.sOut;
                end
                ST_CAPTURE_F: begin
                    ks_r <= bus.sOut;
                end
                ST_WAIT_IN: begin
                    if (accept_s && !last_s) begin
                        k_r <= k_r + K_ONE;
                    end
                end
                default: begin
                end
            endcase

            // A reload in the same cycle as out_ready gives a bubble-free handoff.
            if (accept_s) begin
                out_data_r  <= bus.in_data ^ ks_r;
                out_idx_r   <= k_r;
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign bus.sAddr     = addr_s;
    assign bus.sIn       = sin_s;
    assign bus.sWren     = wren_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_valid = out_valid_r;
    assign busy          = (state_r != ST_IDLE);
    assign finished      = (state_r == ST_DONE);
endmodule

// File: doc/rc4_encryptor.md
Name: rc4_encryptor

Overview:
- Streaming RC4 encryptor, the transmit-side counterpart of the on-chip decryptor.
- Takes plaintext bytes on a valid/ready input, generates the RC4 keystream (PRGA) against the shared S RAM, and emits ciphertext bytes with their message index on a valid/ready output.
- Sits after the KSA/S-init stage (S already keyed) and feeds the ciphertext message RAM or an external link.

Parameters:
- RAM_WIDTH, 8, S RAM data width and byte width of the data paths.
- RAM_LENGTH, 8, S RAM address width; all i/j/index arithmetic is mod 2^RAM_LENGTH.
- MESSAGE_LOG_LENGTH, 5, width of byte index; max message length is 2^MESSAGE_LOG_LENGTH.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level input, rising edge launches a message.
- msg_len  in  MESSAGE_LOG_LENGTH+1  byte count, sampled on the start edge.
- sOut  in  RAM_WIDTH  S RAM read data, valid 1 cycle after sAddr.
- sIn  out  RAM_WIDTH  S RAM write data.
- sAddr  out  RAM_LENGTH  S RAM address.
- sWren  out  1  S RAM write enable.
- in_data  in  RAM_WIDTH  plaintext byte.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  plaintext accepted when in_valid && in_ready.
- out_data  out  RAM_WIDTH  ciphertext byte.
- out_idx  out  MESSAGE_LOG_LENGTH  index k of out_data.
- out_valid  out  1  ciphertext valid; held with stable data/idx until out_ready.
- out_ready  in  1  downstream accept.
- busy  out  1  high from the start edge until finished.
- finished  out  1  one-cycle pulse after the last byte is accepted at the input.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; i, j, k, si, sj, ks all 0; sWren, in_ready, out_valid, busy and finished all 0; out_data, out_idx, sAddr and sIn all 0. Reset mid-message abandons it; the partial S permutation is not restored.
- IDLE: on the start rising edge, latch msg_len and clear i, j and k. If msg_len==0, go to DONE; otherwise go to FETCH_I. Start edges outside IDLE are ignored.
- FETCH_I: i<=i+1; sAddr=i+1 (combinational next_i).
- READ_SI: si<=sOut; j<=j+sOut; sAddr=j+sOut.
- READ_SJ: sj<=sOut.
- WRITE_SI: sAddr=i; sIn=sj; sWren=1.
- WRITE_SJ: sAddr=j; sIn=si; sWren=1. When i==j, both writes hit the same address with an equal value, so S is unchanged.
- ISSUE_F: sAddr=si+sj, truncated to RAM_LENGTH bits.
- CAPTURE_F: ks<=sOut.
- WAIT_IN:
  - in_ready = !out_valid || out_ready.
  - On accept: out_data<=in_data^ks; out_idx<=k; out_valid<=1.
  - If k==msg_len-1, go to DONE; else k<=k+1 and go to FETCH_I.
- Output register rules:
  - out_valid clears on out_ready unless reloaded in the same cycle.
  - Simultaneous out_ready and a new accept means a back-to-back transfer with no bubble.
- DONE: finished=1 for one cycle, then IDLE. out_valid may still be pending and is drained normally.
- busy = state!=IDLE.
- Keystream latency: 7 cycles from FETCH_I to WAIT_IN. Peak throughput is one byte per 8 cycles.
- S RAM: only this block drives it while busy. sWren is 0 in every state except WRITE_SI and WRITE_SJ.

Decomposition:
- Shared package rc4_pkg: state enum, RAM_WIDTH/RAM_LENGTH defaults, and a shared typedef for byte.
- Sub-module: the existing edge_detector, used on start.
- The PRGA step datapath stays inline.

Test Plan:
- Identity S (s[x]=x), msg_len=2, pt 0x61,0x61, out_ready=1 -> ct 0x63 (ks 0x02), then 0x64 (ks 0x05). After the run: s[2]=3, s[3]=2; finished pulses once; busy falls.
- S preloaded with KSA("Key"), pt "Plaintext" (msg_len=9) -> ct BB F3 16 E8 D9 40 AF 0A D3, out_idx 0..8.
- Same as the previous scenario but out_ready held low for 20 cycles after byte 0 -> out_valid and out_data stay stable, in_ready=0 throughout, no byte is lost or duplicated, and the final ct is unchanged.
- msg_len=0 on start -> no sWren, no out_valid; finished pulses 2 cycles after the start edge (edge-detect latency plus DONE).
- Second start edge mid-message plus in_valid gaps -> the start is ignored and the ciphertext equals the vector from the "Key" scenario.
- reset driven low during WRITE_SJ of byte 3 -> next cycle all outputs are 0 and state is IDLE. A fresh start with a re-initialised S reproduces the "Key" vector.
